// File: rtl/solar_pkg.sv
// Shared types and constants for the two-axis solar tracker.
package solar_pkg;

  // Per-axis controller state.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_POS,
    ST_RUN_NEG,
    ST_SETTLE,
    ST_FAULT
  } axis_state_t;

  // Axis indices into the packed per-axis vectors.
  localparam int NUM_AXES = 2;
  localparam int AX_NS    = 0;
  localparam int AX_EW    = 1;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/solar_axis.sv
// One tracker axis: hysteretic start/stop, run timeout with sticky fault,
// and a motors-off settle dwell after every stop.
module solar_axis
  import solar_pkg::*;
#(
  parameter int W       = 16,
  parameter int MAX_RUN = 4096,
  parameter int SETTLE  = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         go_ok,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] th_start,
  input  logic [W-1:0] th_stop,
  input  logic         fault_clr,
  output logic         mpos,
  output logic         mneg,
  output logic         fault,
  output logic         idle,
  output logic         start_req
);

  localparam int CW = $clog2(max_int(MAX_RUN, SETTLE) + 1);
  localparam logic [CW-1:0] RUN_LAST    = CW'(MAX_RUN - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  axis_state_t   state;
  logic [CW-1:0] cnt;

  // Comparisons run one bit wider so sensor + threshold can never wrap.
  logic [W:0] a_x, b_x, a_start, b_start, a_stop, b_stop;
  logic       up, dn, stop_pos, stop_neg;

  assign a_x      = {1'b0, a};
  assign b_x      = {1'b0, b};
  assign a_start  = a_x + {1'b0, th_start};
  assign b_start  = b_x + {1'b0, th_start};
  assign a_stop   = a_x + {1'b0, th_stop};
  assign b_stop   = b_x + {1'b0, th_stop};
  assign up       = a_x > b_start;
  assign dn       = b_x > a_start;
  assign stop_pos = a_x <= b_stop;
  assign stop_neg = b_x <= a_stop;

  // Start request is not gated by go_ok so the top can arbitrate on it.
  assign start_req = (state == ST_IDLE) && en && (up || dn);

  // State and shared run/settle counter; stop takes precedence over timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (en && go_ok && up)      state <= ST_RUN_POS;
          else if (en && go_ok && dn) state <= ST_RUN_NEG;
        end
        ST_RUN_POS, ST_RUN_NEG: begin
          if (!en || (state == ST_RUN_POS ? stop_pos : stop_neg)) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end else if (cnt == RUN_LAST) begin
            state <= ST_FAULT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_FAULT: begin
          cnt <= '0;
          if (fault_clr) state <= ST_SETTLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign mpos  = (state == ST_RUN_POS);
  assign mneg  = (state == ST_RUN_NEG);
  assign fault = (state == ST_FAULT);
  assign idle  = (state == ST_IDLE);

endmodule

// File: rtl/solar_tracker.sv
// Two-axis light-balance tracker: NS and EW axis controllers, optional
// one-axis-at-a-time arbitration, and motor pin mapping.
module solar_tracker
  import solar_pkg::*;
#(
  parameter int W       = 16,
  parameter int MAX_RUN = 4096,
  parameter int SETTLE  = 256,
  parameter int SERIAL  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] th_start,
  input  logic [W-1:0] th_stop,
  input  logic [W-1:0] lsn,
  input  logic [W-1:0] lse,
  input  logic [W-1:0] lss,
  input  logic [W-1:0] lsw,
  input  logic         fault_clr,
  output logic         mn,
  output logic         me,
  output logic         ms,
  output logic         mw,
  output logic         busy,
  output logic         fault_ns,
  output logic         fault_ew
);

  logic [NUM_AXES-1:0][W-1:0] a, b;
  logic [NUM_AXES-1:0]        go_ok, mpos, mneg, fault, idle, start_req;

  assign a[AX_NS] = lsn;
  assign b[AX_NS] = lss;
  assign a[AX_EW] = lse;
  assign b[AX_EW] = lsw;

  // Serial mode: NS wins a simultaneous start; SETTLE/FAULT occupy the slot.
  generate
    if (SERIAL != 0) begin : g_serial
      assign go_ok[AX_NS] = idle[AX_EW];
      assign go_ok[AX_EW] = idle[AX_NS] && !start_req[AX_NS];
    end else begin : g_indep
      assign go_ok = '1;
    end
  endgenerate

  genvar g;
  generate
    for (g = 0; g < NUM_AXES; g++) begin : g_axis
      solar_axis #(
        .W       (W),
        .MAX_RUN (MAX_RUN),
        .SETTLE  (SETTLE)
      ) u_axis (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .go_ok     (go_ok[g]),
        .a         (a[g]),
        .b         (b[g]),
        .th_start  (th_start),
        .th_stop   (th_stop),
        .fault_clr (fault_clr),
        .mpos      (mpos[g]),
        .mneg      (mneg[g]),
        .fault     (fault[g]),
        .idle      (idle[g]),
        .start_req (start_req[g])
      );
    end
  endgenerate

  assign mn       = mpos[AX_NS];
  assign ms       = mneg[AX_NS];
  assign me       = mpos[AX_EW];
  assign mw       = mneg[AX_EW];
  assign fault_ns = fault[AX_NS];
  assign fault_ew = fault[AX_EW];
  assign busy     = ~&idle;

endmodule

// File: tb/tb_solar_tracker.sv
// Directed bench for solar_tracker (MAX_RUN=8, SETTLE=4). A second,
// SERIAL=0 instance shares all inputs and is checked only in the
// independent-axes scenario.
module tb_solar_tracker;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, en, fault_clr;
  logic [W-1:0] th_start, th_stop, lsn, lse, lss, lsw;
  logic         mn, me, ms, mw, busy, fault_ns, fault_ew;
  logic         mn0, me0, ms0, mw0, busy0, fault_ns0, fault_ew0;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  solar_tracker #(.W(W), .MAX_RUN(8), .SETTLE(4), .SERIAL(1)) dut (
    .clk(clk), .rst(rst), .en(en), .th_start(th_start), .th_stop(th_stop),
    .lsn(lsn), .lse(lse), .lss(lss), .lsw(lsw), .fault_clr(fault_clr),
    .mn(mn), .me(me), .ms(ms), .mw(mw), .busy(busy),
    .fault_ns(fault_ns), .fault_ew(fault_ew)
  );

  solar_tracker #(.W(W), .MAX_RUN(8), .SETTLE(4), .SERIAL(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .th_start(th_start), .th_stop(th_stop),
    .lsn(lsn), .lse(lse), .lss(lss), .lsw(lsw), .fault_clr(fault_clr),
    .mn(mn0), .me(me0), .ms(ms0), .mw(mw0), .busy(busy0),
    .fault_ns(fault_ns0), .fault_ew(fault_ew0)
  );

  // Advance one edge and sample 1 ns later.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Motors all off, no faults.
  task automatic chk_quiet(input string tag);
    chk({tag, ".mn"}, mn, 1'b0);
    chk({tag, ".ms"}, ms, 1'b0);
    chk({tag, ".me"}, me, 1'b0);
    chk({tag, ".mw"}, mw, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".fault_ns"}, fault_ns, 1'b0);
    chk({tag, ".fault_ew"}, fault_ew, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; fault_clr = 1'b0;
    th_start = 16'd100; th_stop = 16'd20;
    lsn = 16'd5000; lss = 16'd0; lse = 16'd0; lsw = 16'd0;

    // Reset held 3 cycles with a strong N imbalance.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("reset");
    end
    rst = 1'b0;
    tick();
    chk("rst_release.mn", mn, 1'b1);
    chk("rst_release.busy", busy, 1'b1);

    // Hysteresis: 150 keeps running, 20 stops, 100 does not restart.
    lsn = 16'd1000; lss = 16'd850;
    tick();
    chk("hyst_run.mn", mn, 1'b1);
    lsn = 16'd870;
    tick();
    chk("hyst_stop.mn", mn, 1'b0);
    chk("hyst_stop.busy", busy, 1'b1);
    lsn = 16'd950;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hyst_settle.busy", busy, 1'b1);
      chk("hyst_settle.mn", mn, 1'b0);
    end
    tick();
    chk("hyst_idle.busy", busy, 1'b0);
    tick(2);
    chk("hyst_norestart.mn", mn, 1'b0);
    chk("hyst_norestart.busy", busy, 1'b0);

    // Timeout on EW: 8 run cycles then sticky fault.
    lsn = 16'd0; lss = 16'd0; lse = 16'd3000; lsw = 16'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("timeout_run.me", me, 1'b1);
    end
    tick();
    chk("timeout_trip.me", me, 1'b0);
    chk("timeout_trip.fault_ew", fault_ew, 1'b1);
    chk("timeout_trip.fault_ns", fault_ns, 1'b0);
    tick(2);
    chk("fault_sticky.fault_ew", fault_ew, 1'b1);
    chk("fault_sticky.me", me, 1'b0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("fault_clr.fault_ew", fault_ew, 1'b0);
    chk("fault_clr.busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_settle.me", me, 1'b0);
      chk("clr_settle.busy", busy, 1'b1);
    end
    tick();
    chk("clr_idle.busy", busy, 1'b0);
    tick();
    chk("clr_restart.me", me, 1'b1);
    lse = 16'd0;
    tick();
    chk("ew_stop.me", me, 1'b0);
    tick(4);
    chk_quiet("ew_stopped");

    // Overflow-safe comparisons near full scale.
    lsn = 16'hFFFF; lss = 16'd65500;
    tick(2);
    chk_quiet("ovf_sum");
    lss = 16'd0; th_start = 16'hFFFF;
    tick(2);
    chk_quiet("ovf_th");
    th_start = 16'd100; lsn = 16'd0;
    tick();

    // Serial arbitration: NS wins, EW waits for NS settle.
    lsn = 16'd1000; lse = 16'd1000;
    tick();
    chk("serial_start.mn", mn, 1'b1);
    chk("serial_start.me", me, 1'b0);
    tick();
    chk("serial_hold.me", me, 1'b0);
    lsn = 16'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("serial_wait.mn", mn, 1'b0);
      chk("serial_wait.me", me, 1'b0);
    end
    tick();
    chk("serial_ew_go.me", me, 1'b1);

    // Same stimulus on independent axes: both start together.
    rst = 1'b1; lsn = 16'd0; lse = 16'd0;
    tick();
    chk("reset_mid_run.me", me, 1'b0);
    chk("reset_mid_run.busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    lsn = 16'd1000; lse = 16'd1000;
    tick();
    chk("indep.mn0", mn0, 1'b1);
    chk("indep.me0", me0, 1'b1);
    chk("indep_serial.me", me, 1'b0);

    // Enable drop on a west move, re-enable mid-settle.
    rst = 1'b1; lsn = 16'd0; lse = 16'd0;
    tick();
    rst = 1'b0;
    lsw = 16'd1000;
    tick();
    chk("endrop_run.mw", mw, 1'b1);
    tick();
    chk("endrop_run2.mw", mw, 1'b1);
    en = 1'b0;
    tick();
    chk("endrop_stop.mw", mw, 1'b0);
    chk("endrop_stop.busy", busy, 1'b1);
    chk("endrop_stop.fault_ew", fault_ew, 1'b0);
    tick();
    en = 1'b1;
    tick(2);
    chk("endrop_settle.mw", mw, 1'b0);
    chk("endrop_settle.busy", busy, 1'b1);
    tick();
    chk("endrop_idle.busy", busy, 1'b0);
    chk("endrop_idle.mw", mw, 1'b0);
    tick();
    chk("endrop_restart.mw", mw, 1'b1);
    chk("endrop_restart.fault_ew", fault_ew, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/solar_tracker.md
# solar_tracker

Two-axis, parametrised successor to the single-FSM light-balance controller. Compares opposing light-sensor pairs (N/S, E/W) and drives one motor enable per direction. Adds start/stop hysteresis, overflow-safe comparison, a per-axis motor run timeout with a sticky fault, a post-move settle dwell, a global enable and an optional one-axis-at-a-time mode. Sits between the sensor ADC sample registers and the motor driver pins.

## Interface
- W, 16: sensor and threshold width (bits).
- MAX_RUN, 4096: maximum consecutive cycles one motor may be on before that axis faults (≥2).
- SETTLE, 256: cycles the axis dwells with motors off after any stop (≥1).
- SERIAL, 1: 1 = only one axis may run at a time; 0 = axes independent.
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable; low stops motion.
- th_start  in  W  imbalance required to start a move.
- th_stop  in  W  imbalance at or below which a move ends (th_stop ≤ th_start is the caller's responsibility).
- lsn, lse, lss, lsw  in  W each  sensor samples.
- fault_clr  in  1  one-cycle pulse; clears faults on both axes.
- mn, me, ms, mw  out  1 each  motor enables.
- busy  out  1  either axis not IDLE.
- fault_ns, fault_ew  out  1 each  sticky per-axis timeout fault.

## Operation
- Each axis has a positive sensor a and a negative sensor b: NS a=lsn, b=lss; EW a=lse, b=lsw. States: IDLE, RUN_POS, RUN_NEG, SETTLE, FAULT.
- Arithmetic: all sums computed at W+1 bits, zero-extended, so no wrap. up = a > b+th_start; dn = b > a+th_start; stop_pos = a ≤ b+th_stop; stop_neg = b ≤ a+th_stop.
- IDLE: en && up → RUN_POS; else en && dn → RUN_NEG (up and dn are mutually exclusive). Otherwise stay.
- RUN_POS: !en or stop_pos → SETTLE; else run counter reaches MAX_RUN → FAULT. If both hold in the same cycle, stop wins and no fault is raised. A reversal (dn) implies stop_pos, so the axis never reverses directly.
- RUN_NEG: mirror of RUN_POS using stop_neg.
- SETTLE: the counter counts to SETTLE, then → IDLE. en does not shorten the dwell.
- FAULT: motors off, fault_x=1. Exits to SETTLE only on fault_clr; otherwise ignores en and the sensors.
- Run counter: cleared on entry to RUN_*; increments each RUN cycle. A motor is therefore high for at most MAX_RUN consecutive cycles. The counter is reused for SETTLE.
- SERIAL=1: EW may leave IDLE only if NS is IDLE and NS is not starting in the same cycle, so NS has priority on simultaneous start. NS may start only if EW is IDLE. SETTLE and FAULT count as occupied.
- Outputs: decoded from registered state. mn=NS RUN_POS, ms=NS RUN_NEG, me=EW RUN_POS, mw=EW RUN_NEG. mn&ms and me&mw are never both 1.

## Timing
- Reset: rst sampled at a clk edge forces both axes to IDLE, counters to 0, faults to 0. All outputs are 0 from the edge where rst is sampled high, and stay 0 while rst is held. Reset mid-run or mid-fault takes effect on that same edge.
- Latency: condition sampled at edge k → motor output changes after edge k (1 cycle). There is no combinational path from inputs to outputs.
- First edge after rst deasserts may already start a move.
- fault_clr and a timeout on the same edge (other axis): the clear applies only to axes already in FAULT.
- busy = OR of both axes not being in IDLE. It is registered-state derived, so it has the same 1-cycle latency.

## Structure
- solar_pkg: axis state enum (IDLE, RUN_POS, RUN_NEG, SETTLE, FAULT) and shared helper constants.
- Sub-module solar_axis: one instance per axis. Ports: clk, rst, en, go_ok (serial gate), a, b, th_start, th_stop, fault_clr; outputs mpos, mneg, fault, idle, start_req. Counter width is $clog2(max(MAX_RUN, SETTLE)+1).
- Top solar_tracker: two instances, the SERIAL arbitration and the output mapping.

## Test plan
Parameters for all scenarios: W=16, MAX_RUN=8, SETTLE=4, SERIAL=1, th_start=100, th_stop=20, en=1 unless stated.
- Reset: lsn=5000, lss=0 with rst held 3 cycles → all outputs 0 throughout; mn=1 after the first edge following release.
- Hysteresis: lsn=1000, lss=850 → mn=1. Set lsn=870 → mn=0 next edge, busy stays 1 for 4 cycles, then IDLE. Set lsn=950 (diff exactly 100) → no restart.
- Timeout: lse=3000, lsw=0 held → me=1 for exactly 8 cycles, then me=0 and fault_ew=1 persists. Pulse fault_clr → fault_ew=0, 4-cycle settle, then me=1 again.
- Overflow: lsn=65535, lss=65500 → no motion, because the sum is 65600 at 17 bits. lss=0, lsn=65535, th_start=65535 → no motion.
- Serial arbitration: lsn=1000, lss=0, lse=1000, lsw=0 applied together → mn=1, me=0. Drop lsn to 0 → me rises only after NS finishes its settle. Repeat with SERIAL=0 → mn and me rise on the same edge.
- Enable drop: running mw, deassert en → mw=0 next edge, 4-cycle settle, no fault. Re-assert en mid-settle → settle completes, then mw restarts.
